// File: rtl/wf_gather_pkg.sv
// Shared constants and record layout for the wavefront-completion gather controller.
package wf_gather_pkg;

  localparam int CU_ID_W   = 3;
  localparam int TAG_W_DEF = 35;
  localparam int RECORD_W  = CU_ID_W + TAG_W_DEF;

  typedef struct packed {
    logic [CU_ID_W-1:0]   cu_id;
    logic [TAG_W_DEF-1:0] tag;
  } wf_record_t;

endpackage

// File: rtl/wf_gather_ram_ext.sv
// Two-port gather RAM: one write port and one registered-read port, no reset on storage.
module wf_gather_ram_ext #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             W0_clk,
  input  logic             W0_en,
  input  logic [AW-1:0]    W0_addr,
  input  logic [WIDTH-1:0] W0_data,
  input  logic             R0_clk,
  input  logic             R0_en,
  input  logic [AW-1:0]    R0_addr,
  output logic [WIDTH-1:0] R0_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      r_mem[W0_addr] <= W0_data;
    end
  end

  // Read port: data appears the cycle after the read is issued and holds until the next read
  always_ff @(posedge R0_clk) begin
    if (R0_en) begin
      r_rdata <= r_mem[R0_addr];
    end
  end

  assign R0_data = r_rdata;

endmodule

// File: rtl/wf_gather_ctrl.sv
// Round-robin gather of per-CU wavefront-done reports into a small RAM, drained in order
// through a valid/ready port whose two-entry output stage is the RAM read register plus a skid.
module wf_gather_ctrl
  import wf_gather_pkg::*;
#(
  parameter int N_CU  = 4,
  parameter int TAG_W = 35,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_flush,
  input  logic [N_CU-1:0]          io_req_valid,
  output logic [N_CU-1:0]          io_req_ready,
  input  logic [N_CU*TAG_W-1:0]    io_req_tag,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [CU_ID_W+TAG_W-1:0] io_out_bits,
  output logic [3:0]               io_count,
  output logic                     io_full
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             REC_W   = CU_ID_W + TAG_W;
  localparam logic [3:0]     DEPTH_L = 4'(DEPTH);
  localparam logic [3:0]     NCU_L   = 4'(N_CU);
  localparam logic [2:0]     LAST_CU = 3'(N_CU - 1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);

  logic [2:0]       r_rr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_ram_vld;
  logic             r_skid_vld;
  logic [REC_W-1:0] r_skid;

  logic [2*N_CU-1:0] w_req_dbl;
  logic [N_CU-1:0]   w_req_rot;
  logic              w_found;
  logic [2:0]        w_ofs;
  logic [3:0]        w_sum;
  logic [2:0]        w_gnt_id;
  logic [TAG_W-1:0]  w_gnt_tag;
  logic              w_block;
  logic              w_grant;
  logic [REC_W-1:0]  w_rd_data;
  logic              w_out_valid;
  logic              w_pop;
  logic [1:0]        w_occ_after;
  logic              w_rd;
  logic              w_ram_keep;

  assign w_block   = reset | io_flush;
  assign w_req_dbl = {io_req_valid, io_req_valid};
  assign w_req_rot = N_CU'(w_req_dbl >> r_rr);

  // Arbiter: first valid CU at or after rr, found on the rotated request vector
  always_comb begin
    w_ofs = 3'd0;
    for (int k = N_CU - 1; k >= 0; k--) begin
      w_ofs = w_req_rot[k] ? 3'(k) : w_ofs;
    end
    w_found  = |w_req_rot;
    w_sum    = {1'b0, r_rr} + {1'b0, w_ofs};
    w_gnt_id = (w_sum >= NCU_L) ? 3'(w_sum - NCU_L) : w_sum[2:0];
    w_grant  = w_found & ~w_block & (r_count != DEPTH_L);
  end

  // Grant decode and tag select
  always_comb begin
    io_req_ready = '0;
    w_gnt_tag    = '0;
    for (int i = 0; i < N_CU; i++) begin
      io_req_ready[i] = w_grant & (w_gnt_id == 3'(i));
      w_gnt_tag       = (w_gnt_id == 3'(i)) ? io_req_tag[i*TAG_W +: TAG_W] : w_gnt_tag;
    end
  end

  // A read may refill a slot the consumer frees in this same cycle, giving one record per cycle
  assign w_out_valid = (r_skid_vld | r_ram_vld) & ~w_block;
  assign w_pop       = w_out_valid & io_out_ready;
  assign w_occ_after = {1'b0, r_skid_vld} + {1'b0, r_ram_vld} - {1'b0, w_pop};
  assign w_rd        = ~w_block & (r_count != 4'd0) & (w_occ_after < 2'd2);
  assign w_ram_keep  = r_ram_vld & ~(w_pop & ~r_skid_vld);

  // Round-robin pointer; survives flush
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr <= 3'd0;
    end else if (w_grant) begin
      r_rr <= (w_gnt_id == LAST_CU) ? 3'd0 : w_gnt_id + 3'd1;
    end else begin
      r_rr <= r_rr;
    end
  end

  // RAM pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      r_wr_ptr <= w_grant ? r_wr_ptr + PTR_ONE : r_wr_ptr;
      r_rd_ptr <= w_rd ? r_rd_ptr + PTR_ONE : r_rd_ptr;
      r_count  <= r_count + {3'b000, w_grant} - {3'b000, w_rd};
    end
  end

  // Output stage: an unconsumed RAM record moves to the skid before a new read overwrites it
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      r_ram_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
    end else begin
      r_ram_vld <= w_rd | w_ram_keep;
      if (w_ram_keep && w_rd) begin
        r_skid_vld <= 1'b1;
        r_skid     <= w_rd_data;
      end else begin
        r_skid_vld <= r_skid_vld & ~w_pop;
        r_skid     <= r_skid;
      end
    end
  end

  wf_gather_ram_ext #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .AW    (AW)
  ) u_ram (
    .W0_clk  (clock),
    .W0_en   (w_grant),
    .W0_addr (r_wr_ptr),
    .W0_data ({w_gnt_id, w_gnt_tag}),
    .R0_clk  (clock),
    .R0_en   (w_rd),
    .R0_addr (r_rd_ptr),
    .R0_data (w_rd_data)
  );

  assign io_out_valid = w_out_valid;
  assign io_out_bits  = r_skid_vld ? r_skid : (r_ram_vld ? w_rd_data : '0);
  assign io_count     = r_count;
  assign io_full      = (r_count == DEPTH_L);

endmodule
